out_buffer_ctrl: RTL and testbench
==================================

Name: out_buffer_ctrl

Overview:
Parametrised output-buffer controller that owns a single-port word SRAM. Arbitrates the SRAM between the EPU datapath during a layer run and the host bus outside a run. Adds burst reads and writes, byte strobes, read backpressure through a 2-entry output FIFO, and error reporting. Sits between the EPU wrapper's host-side slave logic and the EPU core.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
DEPTH, 98304, SRAM depth in words (384 KB at 32 bits).
ADDR_W, $clog2(DEPTH), word-address width.
HADDR_W, 20, host byte-address width.
LEN_W, 4, burst length field width; burst = len+1 beats, maximum 16.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enb_i  in  1  host selects this buffer
start_i  in  1  EPU run start pulse
finish_i  in  1  EPU run done pulse
busy_o  out  1  EPU owns the buffer (or clear sweep in progress)
h_req_i  in  1  host burst request
h_we_i  in  1  1 = write burst, 0 = read burst
h_addr_i  in  HADDR_W  byte start address
h_len_i  in  LEN_W  beats minus 1
h_ack_o  out  1  one-cycle request accept
h_wvalid_i  in  1  write beat valid
h_wdata_i  in  DATA_W  write data
h_wstrb_i  in  DATA_W/8  byte strobes
h_wlast_i  in  1  final write beat marker
h_wready_o  out  1  write beat accepted
h_rvalid_o  out  1  read beat valid
h_rdata_o  out  DATA_W  read data
h_rlast_o  out  1  final read beat
h_rready_i  in  1  host accepts read beat
h_err_o  out  1  one-cycle error pulse
epu_cs_i  in  1  EPU chip select
epu_oe_i  in  1  EPU output enable
epu_we_i  in  DATA_W/8  EPU byte write enables
epu_addr_i  in  ADDR_W  EPU word address
epu_wdata_i  in  DATA_W  EPU write data
epu_rdata_o  out  DATA_W  EPU read data

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset:
  - State goes to IDLE and the FIFO is flushed.
  - All outputs are 0.
  - SRAM contents are retained.
  - Reset asserted mid-burst or mid-run aborts the operation with no further SRAM writes.
- SRAM: read latency 1 cycle; byte-strobed writes.
- Word address = h_addr_i >> log2(DATA_W/8), truncated to ADDR_W. Increments modulo DEPTH per beat.
- States: IDLE, CLR (optional), EPU_RW, H_RD, H_WR.
- IDLE:
  - start_i has priority over everything and goes to EPU_RW (or CLR).
  - Else h_req_i & enb_i: h_ack_o=1 that same cycle; latch address, length and direction; next state H_RD or H_WR.
  - h_req_i without enb_i is ignored.
- Start-address range check, done at ack:
  - If start word index >= DEPTH, h_err_o pulses in the cycle after ack.
  - The burst still runs the full length, but writes are suppressed and read data is 0.
- EPU_RW:
  - SRAM is driven directly by the epu_* ports; epu_rdata_o is valid 1 cycle after cs&oe.
  - busy_o=1. Host requests are not acked.
  - finish_i moves to IDLE next cycle; start_i need not be held.
  - Outside EPU_RW, epu_rdata_o=0 and EPU writes are ignored.
- H_WR:
  - h_wready_o=1. Each h_wvalid_i beat writes h_wstrb_i-masked data, then address+1 and beat count+1.
  - After beat len+1 the state returns to IDLE; h_wready_o drops that same cycle.
  - h_wlast_i mismatch: asserted on a non-final beat, or absent on the final beat, gives a one-cycle h_err_o on that beat. Burst length is governed by the count only.
- H_RD:
  - Issue a read only when FIFO occupancy plus reads in flight is < 2.
  - h_rvalid_o = FIFO not empty. A beat pops on h_rvalid_o & h_rready_i.
  - h_rlast_o accompanies beat len+1. The state returns to IDLE on the cycle the last beat pops.
  - First h_rvalid_o is 2 cycles after the ack cycle. With h_rready_i held high, throughput is 1 beat/cycle.
  - h_rdata_o is held stable while h_rvalid_o & !h_rready_i.
- start_i during H_RD or H_WR: ignored; the burst completes first.
- finish_i outside EPU_RW: ignored.

Optional Feature:
- Macro: OUTBUF_CLR_EN.
- Defined:
  - start_i enters CLR, which zero-writes every word 0..DEPTH-1, one per cycle, then enters EPU_RW.
  - busy_o=1 throughout CLR; EPU accesses during CLR are ignored; finish_i is ignored in CLR.
  - The EPU run sees an all-zero buffer.
- Undefined: start_i enters EPU_RW directly; no CLR state exists; contents persist across runs.

Test Plan:
- DEPTH=64. Write burst at addr 0x10, len 3, data 0xA0..0xA3, strobes 0xF, wlast on beat 4 -> words 4..7 hold 0xA0..0xA3; h_err_o stays 0; IDLE afterwards.
- Read burst at addr 0x10, len 3, rready toggling 1,0,1,1,0,1 -> beats 0xA0..0xA3 delivered in order, data stable while stalled, rlast only on 0xA3, first rvalid 2 cycles after ack.
- Write at word 62, len 3 -> writes land at words 62, 63, 0, 1. Write with strb 0x3 of 0xFFFFFFFF over 0x12345678 -> word reads 0x1234FFFF.
- start_i and h_req_i asserted in the same cycle -> no h_ack_o; EPU writes 0x55 at addr 9; finish_i; host read of word 9 returns 0x55. h_req_i held during EPU_RW is acked only after return to IDLE.
- Write burst len 1 with wlast on beat 1 -> h_err_o pulse on beat 1 and 2 beats written. Start addr 0x100 (word 64 >= DEPTH) -> h_err_o after ack; a read returns zeros.
- rst asserted mid read burst -> next cycle IDLE, h_rvalid_o=0; with OUTBUF_CLR_EN, start_i -> busy_o high for 64 cycles and all words read 0 after the run.

Source files
------------

// File: rtl/out_buffer_ctrl_if.sv
// ============================================================================
// Module      : out_buffer_ctrl_if
// Description : Host burst bus between the EPU wrapper slave logic and the
//               output-buffer controller. Carries the request/ack handshake,
//               the write-beat channel, the read-beat channel and the error
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface out_buffer_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int HADDR_W = 20,
  parameter int LEN_W   = 4
) ();

  logic                  h_req_i;
  logic                  h_we_i;
  logic [HADDR_W-1:0]    h_addr_i;
  logic [LEN_W-1:0]      h_len_i;
  logic                  h_ack_o;
  logic                  h_wvalid_i;
  logic [DATA_W-1:0]     h_wdata_i;
  logic [DATA_W/8-1:0]   h_wstrb_i;
  logic                  h_wlast_i;
  logic                  h_wready_o;
  logic                  h_rvalid_o;
  logic [DATA_W-1:0]     h_rdata_o;
  logic                  h_rlast_o;
  logic                  h_rready_i;
  logic                  h_err_o;

  // Buffer side: the controller receives requests and beats.
  modport slave (
    input  h_req_i, h_we_i, h_addr_i, h_len_i,
    input  h_wvalid_i, h_wdata_i, h_wstrb_i, h_wlast_i,
    input  h_rready_i,
    output h_ack_o, h_wready_o, h_rvalid_o, h_rdata_o, h_rlast_o, h_err_o
  );

  // Host side: issues requests and beats.
  modport master (
    output h_req_i, h_we_i, h_addr_i, h_len_i,
    output h_wvalid_i, h_wdata_i, h_wstrb_i, h_wlast_i,
    output h_rready_i,
    input  h_ack_o, h_wready_o, h_rvalid_o, h_rdata_o, h_rlast_o, h_err_o
  );

endinterface

`default_nettype wire

// File: rtl/out_buffer_ctrl.sv
// ============================================================================
// Module      : out_buffer_ctrl
// Description : Output-buffer controller owning a single-port word SRAM.
//               The EPU drives the SRAM directly during a layer run; outside
//               a run the host gets burst reads/writes with byte strobes, a
//               2-entry read FIFO for backpressure and error pulses.
//               Optional macro OUTBUF_CLR_EN: a run start first zero-fills
//               the whole SRAM (CLR state) before handing it to the EPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_buffer_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 98304,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int HADDR_W = 20,
  parameter int LEN_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb_i,
  input  logic                  start_i,
  input  logic                  finish_i,
  output logic                  busy_o,
  out_buffer_ctrl_if.slave      hif,
  input  logic                  epu_cs_i,
  input  logic                  epu_oe_i,
  input  logic [DATA_W/8-1:0]   epu_we_i,
  input  logic [ADDR_W-1:0]     epu_addr_i,
  input  logic [DATA_W-1:0]     epu_wdata_i,
  output logic [DATA_W-1:0]     epu_rdata_o
);

  localparam int          NB      = DATA_W / 8;
  localparam int          SHIFT   = $clog2(NB);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EPU,
    ST_HRD,
    ST_HWR
`ifdef OUTBUF_CLR_EN
    , ST_CLR
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;       // next SRAM word of the burst
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 oor_q, oor_d;         // burst start was out of range
  logic                 err_pulse_q, err_pulse_d;
  logic [LEN_W:0]       beat_q, beat_d;       // beats written / popped
  logic [LEN_W:0]       issued_q, issued_d;   // SRAM reads issued in H_RD
  logic                 inflight_q;
  logic                 epu_rd_q;
`ifdef OUTBUF_CLR_EN
  logic [ADDR_W-1:0]    clr_q, clr_d;
`endif

  // Read FIFO
  logic [DATA_W-1:0]    fifo_q [2];
  logic                 wptr_q, rptr_q;
  logic [1:0]           fcnt_q;

  // SRAM port
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    sram_q;
  logic [ADDR_W-1:0]    mem_addr;
  logic [NB-1:0]        mem_we;
  logic                 mem_re;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_ok;

  logic                 w_ack, w_wready, w_wlast_err, w_host_rd;
  logic                 w_rvalid, w_pop, w_rlast, w_last_beat;
  logic [2:0]           w_occ;
  logic [HADDR_W-1:0]   w_hword;
  logic [ADDR_W-1:0]    w_hstart;
  logic                 w_start_oor;

  // The range check uses the untruncated word index so that an address
  // past the end cannot alias back into the array.
  assign w_hword     = hif.h_addr_i >> SHIFT;
  assign w_hstart    = ADDR_W'(w_hword);
  assign w_start_oor = (32'(w_hword) >= DEPTH_U);

  assign w_rvalid    = (fcnt_q != 2'd0);
  assign w_pop       = w_rvalid & hif.h_rready_i;
  assign w_rlast     = w_rvalid & (beat_q == {1'b0, len_q});
  assign w_last_beat = (beat_q == {1'b0, len_q});
  // Occupancy counts a pop happening this cycle, so that a steady ready
  // stream keeps one read issued per cycle.
  assign w_occ = {1'b0, fcnt_q} - {2'b0, w_pop} + {2'b0, inflight_q};

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_mem_full
      assign mem_ok = 1'b1;
    end else begin : g_mem_partial
      assign mem_ok = (32'(mem_addr) < DEPTH_U);
    end
  endgenerate

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Next-state, SRAM port arbitration and host handshake decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    oor_d       = oor_q;
    err_pulse_d = 1'b0;
    beat_d      = beat_q;
    issued_d    = issued_q;
    mem_addr    = addr_q;
    mem_we      = '0;
    mem_re      = 1'b0;
    mem_wdata   = hif.h_wdata_i;
    w_ack       = 1'b0;
    w_wready    = 1'b0;
    w_wlast_err = 1'b0;
    w_host_rd   = 1'b0;
`ifdef OUTBUF_CLR_EN
    clr_d       = clr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef OUTBUF_CLR_EN
          state_d = ST_CLR;
          clr_d   = '0;
`else
          state_d = ST_EPU;
`endif
        end else if (hif.h_req_i && enb_i) begin
          w_ack       = 1'b1;
          len_d       = hif.h_len_i;
          oor_d       = w_start_oor;
          err_pulse_d = w_start_oor;
          beat_d      = '0;
          if (hif.h_we_i) begin
            state_d  = ST_HWR;
            addr_d   = w_hstart;
            issued_d = '0;
          end else begin
            // First read goes out in the ack cycle to meet the 2-cycle
            // ack-to-rvalid latency.
            state_d   = ST_HRD;
            mem_addr  = w_hstart;
            mem_re    = 1'b1;
            w_host_rd = 1'b1;
            addr_d    = wrap_inc(w_hstart);
            issued_d  = (LEN_W+1)'(1);
          end
        end
      end
`ifdef OUTBUF_CLR_EN
      ST_CLR: begin
        mem_addr  = clr_q;
        mem_we    = '1;
        mem_wdata = '0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == ADDR_W'(DEPTH - 1)) state_d = ST_EPU;
      end
`endif
      ST_EPU: begin
        mem_addr  = epu_addr_i;
        mem_wdata = epu_wdata_i;
        if (epu_cs_i) begin
          mem_we = epu_we_i;
          mem_re = epu_oe_i;
        end
        if (finish_i) state_d = ST_IDLE;
      end
      ST_HWR: begin
        w_wready = 1'b1;
        if (hif.h_wvalid_i) begin
          mem_we      = oor_q ? '0 : hif.h_wstrb_i;
          w_wlast_err = (hif.h_wlast_i != w_last_beat);
          addr_d      = wrap_inc(addr_q);
          beat_d      = beat_q + 1'b1;
          if (w_last_beat) state_d = ST_IDLE;
        end
      end
      ST_HRD: begin
        if (w_pop) beat_d = beat_q + 1'b1;
        if ((issued_q <= {1'b0, len_q}) && (w_occ < 3'd2)) begin
          mem_re    = 1'b1;
          w_host_rd = 1'b1;
          addr_d    = wrap_inc(addr_q);
          issued_d  = issued_q + 1'b1;
        end
        if (w_pop && w_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset aborts everything in the same cycle, including SRAM writes.
    if (rst) begin
      mem_we      = '0;
      mem_re      = 1'b0;
      w_host_rd   = 1'b0;
      w_ack       = 1'b0;
      w_wready    = 1'b0;
      w_wlast_err = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      oor_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      beat_q      <= '0;
      issued_q    <= '0;
      epu_rd_q    <= 1'b0;
`ifdef OUTBUF_CLR_EN
      clr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      oor_q       <= oor_d;
      err_pulse_q <= err_pulse_d;
      beat_q      <= beat_d;
      issued_q    <= issued_d;
      epu_rd_q    <= (state_q == ST_EPU) & epu_cs_i & epu_oe_i;
`ifdef OUTBUF_CLR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  // Read FIFO: captures each host read one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fcnt_q     <= 2'd0;
    end else begin
      inflight_q <= w_host_rd;
      if (inflight_q) begin
        fifo_q[wptr_q] <= oor_q ? '0 : sram_q;
        wptr_q         <= ~wptr_q;
      end
      if (w_pop) rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
    end
  end

  // SRAM array: byte-strobed write, registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (mem_re) sram_q <= mem_ok ? mem[mem_addr] : '0;
  end

  assign hif.h_ack_o    = w_ack;
  assign hif.h_wready_o = w_wready;
  assign hif.h_rvalid_o = !rst && w_rvalid;
  assign hif.h_rdata_o  = (!rst && w_rvalid) ? fifo_q[rptr_q] : '0;
  assign hif.h_rlast_o  = !rst && w_rlast;
  assign hif.h_err_o    = !rst && (err_pulse_q || w_wlast_err);
`ifdef OUTBUF_CLR_EN
  assign busy_o = !rst && ((state_q == ST_EPU) || (state_q == ST_CLR));
`else
  assign busy_o = !rst && (state_q == ST_EPU);
`endif
  assign epu_rdata_o = (!rst && epu_rd_q && (state_q == ST_EPU)) ? sram_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_out_buffer_ctrl.sv
// ============================================================================
// Module      : tb_out_buffer_ctrl
// Description : Self-checking bench for out_buffer_ctrl (DEPTH=64). Keeps a
//               word-array model of the SRAM and checks host bursts, EPU
//               runs, error pulses and reset behaviour. Honours the
//               OUTBUF_CLR_EN macro when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_buffer_ctrl;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int HADDR_W = 20;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic rst, enb, start, finish, busy;
  logic epu_cs, epu_oe;
  logic [3:0]  epu_we;
  logic [ADDR_W-1:0] epu_addr;
  logic [31:0] epu_wdata, epu_rdata;

  always #5 clk = ~clk;

  out_buffer_ctrl_if #(.DATA_W(DATA_W), .HADDR_W(HADDR_W), .LEN_W(LEN_W)) hif ();

  out_buffer_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HADDR_W(HADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .enb_i(enb), .start_i(start), .finish_i(finish),
    .busy_o(busy), .hif(hif),
    .epu_cs_i(epu_cs), .epu_oe_i(epu_oe), .epu_we_i(epu_we),
    .epu_addr_i(epu_addr), .epu_wdata_i(epu_wdata), .epu_rdata_o(epu_rdata)
  );

  // Reference SRAM model
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] dv [16];
  logic [3:0]  sv [16];
  bit          pat [8];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host write burst. bad_beat flips the wlast marker on that beat (-1: none).
  task automatic host_write(input int byte_addr, input int len, input int bad_beat,
                            input int gap_pct);
    int  w   = byte_addr >> 2;
    bit  oor = (w >= DEPTH);
    int  i   = 0;
    int  k;
    bit  v, wl;
    hif.h_req_i = 1'b1; hif.h_we_i = 1'b1;
    hif.h_addr_i = HADDR_W'(byte_addr); hif.h_len_i = LEN_W'(len);
    #1 chk("wr_ack", 32'(hif.h_ack_o), 32'd1);
    tick();
    hif.h_req_i = 1'b0;
    k = 1;
    while (i <= len && k < 300) begin
      v  = ($urandom_range(0, 99) >= gap_pct);
      wl = (i == len) ^ (i == bad_beat);
      hif.h_wvalid_i = v; hif.h_wdata_i = dv[i]; hif.h_wstrb_i = sv[i]; hif.h_wlast_i = wl;
      #1;
      chk("wr_ready", 32'(hif.h_wready_o), 32'd1);
      chk("wr_err", 32'(hif.h_err_o), 32'((k == 1 && oor) || (v && (wl != (i == len)))));
      if (v) begin
        if (!oor) begin
          mdl[(w + i) % DEPTH]   = merge(mdl[(w + i) % DEPTH], dv[i], sv[i]);
          known[(w + i) % DEPTH] = (sv[i] == 4'hF) || known[(w + i) % DEPTH];
        end
        i++;
      end
      tick();
      k++;
    end
    if (k >= 300) timeout("wr_budget");
    hif.h_wvalid_i = 1'b0; hif.h_wlast_i = 1'b0;
    #1 chk("wr_done_ready", 32'(hif.h_wready_o), 32'd0);
  endtask

  // Host read burst. use_pat drives rready from pat[] first, else random.
  task automatic host_read(input int byte_addr, input int len, input bit use_pat,
                           input int npat, input int rdy_pct);
    int  w      = byte_addr >> 2;
    bit  oor    = (w >= DEPTH);
    int  popped = 0;
    int  k, pi, idx;
    bit  r;
    hif.h_req_i = 1'b1; hif.h_we_i = 1'b0;
    hif.h_addr_i = HADDR_W'(byte_addr); hif.h_len_i = LEN_W'(len);
    #1 chk("rd_ack", 32'(hif.h_ack_o), 32'd1);
    tick();
    hif.h_req_i = 1'b0;
    k = 1; pi = 0;
    while (popped <= len && k < 300) begin
      if (k < 2) r = 1'b1;
      else if (use_pat && pi < npat) begin r = pat[pi]; pi++; end
      else if (use_pat) r = 1'b1;
      else r = ($urandom_range(0, 99) < rdy_pct);
      hif.h_rready_i = r;
      #1;
      chk("rd_valid", 32'(hif.h_rvalid_o), 32'(k >= 2));
      chk("rd_err", 32'(hif.h_err_o), 32'(k == 1 && oor));
      if (k >= 2) begin
        idx = (w + popped) % DEPTH;
        if (oor) chk("rd_data_oor", hif.h_rdata_o, 32'd0);
        else if (known[idx]) chk("rd_data", hif.h_rdata_o, mdl[idx]);
        chk("rd_last", 32'(hif.h_rlast_o), 32'(popped == len));
        if (r) popped++;
      end
      tick();
      k++;
    end
    if (k >= 300) timeout("rd_budget");
    hif.h_rready_i = 1'b0;
    #1 chk("rd_idle_valid", 32'(hif.h_rvalid_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, len;
    rst = 1'b1; enb = 1'b1; start = 1'b0; finish = 1'b0;
    epu_cs = 1'b0; epu_oe = 1'b0; epu_we = '0; epu_addr = '0; epu_wdata = '0;
    hif.h_req_i = 1'b0; hif.h_we_i = 1'b0; hif.h_addr_i = '0; hif.h_len_i = '0;
    hif.h_wvalid_i = 1'b0; hif.h_wdata_i = '0; hif.h_wstrb_i = '0; hif.h_wlast_i = 1'b0;
    hif.h_rready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    tick(); tick();
    chk("rst_ack", 32'(hif.h_ack_o), 32'd0);
    chk("rst_wready", 32'(hif.h_wready_o), 32'd0);
    chk("rst_rvalid", 32'(hif.h_rvalid_o), 32'd0);
    chk("rst_rlast", 32'(hif.h_rlast_o), 32'd0);
    chk("rst_err", 32'(hif.h_err_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_epu_rdata", epu_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Basic write then stalled read of words 4..7
    for (int i = 0; i < 4; i++) begin dv[i] = 32'hA0 + 32'(i); sv[i] = 4'hF; end
    host_write(32'h10, 3, -1, 0);
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    host_read(32'h10, 3, 1'b1, 6, 100);
    chk("rd_word7", mdl[7], 32'hA3);

    // Wrap-around write at word 62
    for (int i = 0; i < 4; i++) begin dv[i] = $urandom; sv[i] = 4'hF; end
    host_write(62 * 4, 3, -1, 0);
    host_read(62 * 4, 3, 1'b0, 0, 100);
    host_read(0, 1, 1'b0, 0, 60);

    // Byte strobes
    dv[0] = 32'h12345678; sv[0] = 4'hF;
    host_write(20 * 4, 0, -1, 0);
    dv[0] = 32'hFFFFFFFF; sv[0] = 4'h3;
    host_write(20 * 4, 0, -1, 0);
    chk("strb_model", mdl[20], 32'h1234FFFF);
    host_read(20 * 4, 0, 1'b0, 0, 100);

    // EPU run: start beats a simultaneous host request
    start = 1'b1; hif.h_req_i = 1'b1; hif.h_we_i = 1'b0;
    hif.h_addr_i = HADDR_W'(32'h24); hif.h_len_i = '0;
    #1 chk("start_noack", 32'(hif.h_ack_o), 32'd0);
    tick();
    start = 1'b0;
`ifdef OUTBUF_CLR_EN
    for (int c = 0; c < DEPTH; c++) begin
      chk("clr_busy", 32'(busy), 32'd1);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b1; end
`endif
    chk("epu_busy", 32'(busy), 32'd1);
    chk("epu_noack", 32'(hif.h_ack_o), 32'd0);
    epu_cs = 1'b1; epu_we = 4'hF; epu_addr = 6'd9; epu_wdata = 32'h55;
    tick();
    mdl[9] = 32'h55; known[9] = 1'b1;
    epu_we = 4'h3; epu_addr = 6'd10; epu_wdata = $urandom;
    tick();
    mdl[10] = merge(mdl[10], epu_wdata, 4'h3);
    epu_we = 4'h0; epu_oe = 1'b1; epu_addr = 6'd9;
    tick();
    epu_cs = 1'b0; epu_oe = 1'b0;
    chk("epu_rdata", epu_rdata, mdl[9]);
    chk("epu_hold_noack", 32'(hif.h_ack_o), 32'd0);
    start = 1'b1; finish = 1'b1;
    tick();
    start = 1'b0; finish = 1'b0;
    host_read(32'h24, 0, 1'b0, 0, 100);
    chk("post_run_busy", 32'(busy), 32'd0);
    // EPU port outside a run: writes ignored, read data zero
    epu_cs = 1'b1; epu_oe = 1'b1; epu_we = 4'hF; epu_addr = 6'd9; epu_wdata = 32'hDEAD;
    tick();
    chk("idle_epu_rdata", epu_rdata, 32'd0);
    epu_cs = 1'b0; epu_oe = 1'b0; epu_we = 4'h0;
    host_read(9 * 4, 1, 1'b0, 0, 100);

    // wlast mismatch: early wlast on beat 1 of a 2-beat burst
    dv[0] = 32'hC0DE0001; dv[1] = 32'hC0DE0002; sv[0] = 4'hF; sv[1] = 4'hF;
    host_write(30 * 4, 1, 0, 0);
    host_read(30 * 4, 1, 1'b0, 0, 100);
    // Missing wlast on the final beat
    host_write(32 * 4, 2, 2, 0);

    // Out-of-range start address
    host_write(32'h100, 1, -1, 0);
    host_read(32'h100, 2, 1'b0, 0, 100);
    host_read(0, 0, 1'b0, 0, 100);

    // Reset in the middle of a stalled read burst
    hif.h_req_i = 1'b1; hif.h_we_i = 1'b0; hif.h_addr_i = HADDR_W'(30 * 4);
    hif.h_len_i = 4'd7; hif.h_rready_i = 1'b0;
    #1 chk("rstrd_ack", 32'(hif.h_ack_o), 32'd1);
    tick();
    hif.h_req_i = 1'b0;
    tick(); tick();
    chk("rstrd_valid_before", 32'(hif.h_rvalid_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrd_valid_after", 32'(hif.h_rvalid_o), 32'd0);
    tick();
    chk("rstrd_valid_later", 32'(hif.h_rvalid_o), 32'd0);
    chk("rstrd_busy", 32'(busy), 32'd0);

    // Reset in the middle of a write burst: later beats must not land
    for (int i = 0; i < 4; i++) begin dv[i] = 32'h40400000 + 32'(i); sv[i] = 4'hF; end
    host_write(40 * 4, 3, -1, 0);
    hif.h_req_i = 1'b1; hif.h_we_i = 1'b1; hif.h_addr_i = HADDR_W'(40 * 4); hif.h_len_i = 4'd3;
    #1 chk("rstwr_ack", 32'(hif.h_ack_o), 32'd1);
    tick();
    hif.h_req_i = 1'b0;
    hif.h_wstrb_i = 4'hF; hif.h_wvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hif.h_wdata_i = 32'hBEEF0000 + 32'(i);
      hif.h_wlast_i = (i == 3);
      if (i == 2) rst = 1'b1;
      if (i < 2) mdl[40 + i] = 32'hBEEF0000 + 32'(i);
      tick();
      rst = 1'b0;
    end
    hif.h_wvalid_i = 1'b0; hif.h_wlast_i = 1'b0;
    host_read(40 * 4, 3, 1'b0, 0, 100);

    // Randomized bursts
    for (int n = 0; n < 12; n++) begin
      w   = $urandom_range(0, 69);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          dv[i] = $urandom;
          sv[i] = ($urandom_range(0, 3) == 0) ? 4'(($urandom_range(1, 15))) : 4'hF;
        end
        host_write(w * 4, len,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1, 25);
      end else begin
        host_read(w * 4, len, 1'b0, 0, 70);
      end
    end
    // Final sweep of everything the model knows
    host_read(0, 15, 1'b0, 0, 80);
    host_read(16 * 4, 15, 1'b0, 0, 100);
    host_read(32 * 4, 15, 1'b0, 0, 50);
    host_read(48 * 4, 15, 1'b0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
